// File: rtl/way_age_tracker.sv
// ---------------------------------------------------------------------------
// way_age_tracker
//
// Recency bookkeeping for a single replacement set. Each way has a valid bit
// and an age counter. The ages of the valid ways always form the set
// 0..(count_valid-1): age 0 is the most recently used way and the largest age
// is the LRU victim. The way-selection max-tree downstream consumes the
// registered ages and the valid mask.
//
// Ports
//   clk_in                rising-edge clock
//   reset_n_in            asynchronous active-low reset
//   invalidate_valid_in   invalidate request      (highest priority)
//   invalidate_way_in     way to invalidate
//   invalidate_ready_out  always 1
//   fill_valid_in         fill request            (middle priority)
//   fill_way_in           way being filled
//   fill_ready_out        ~invalidate_valid_in
//   access_valid_in       hit/touch request       (lowest priority)
//   access_way_in         way being touched
//   access_ready_out      ~invalidate_valid_in & ~fill_valid_in
//   way_flatted_out       registered ages, way i at [i*W +: W]
//   condition_out         registered valid mask
//   free_valid_out        at least one way is invalid
//   free_way_out          lowest-index invalid way, 0 when none
//   all_valid_out         every way is valid
// ---------------------------------------------------------------------------
module way_age_tracker #(
  parameter int NUM_WAY                  = 8,
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int WAY_PTR_WIDTH_IN_BITS    = $clog2(NUM_WAY) + 1
) (
  input  logic                                        clk_in,
  input  logic                                        reset_n_in,

  input  logic                                        invalidate_valid_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]            invalidate_way_in,
  output logic                                        invalidate_ready_out,

  input  logic                                        fill_valid_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]            fill_way_in,
  output logic                                        fill_ready_out,

  input  logic                                        access_valid_in,
  input  logic [WAY_PTR_WIDTH_IN_BITS-1:0]            access_way_in,
  output logic                                        access_ready_out,

  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_out,
  output logic [NUM_WAY-1:0]                          condition_out,
  output logic                                        free_valid_out,
  output logic [WAY_PTR_WIDTH_IN_BITS-1:0]            free_way_out,
  output logic                                        all_valid_out
);

  localparam int W = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int P = WAY_PTR_WIDTH_IN_BITS;

  logic [NUM_WAY-1:0]        valid_q, valid_d;
  logic [NUM_WAY-1:0][W-1:0] age_q, age_d;

  logic                      inv_fire, fill_fire, access_fire;
  logic [P-1:0]              event_way;
  logic [NUM_WAY-1:0]        event_hit;
  logic                      event_valid;
  logic [W-1:0]              event_age;

  // Saturating helpers; with a consistent age set neither limit is reached,
  // they only keep a corrupted state from wrapping around.
  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] a);
    return (a == '1) ? a : a + W'(1);
  endfunction

  function automatic logic [W-1:0] sat_dec(input logic [W-1:0] a);
    return (a == '0) ? a : a - W'(1);
  endfunction

  // Fixed priority invalidate > fill > access. A lower-priority requester
  // simply sees ready low and keeps its request up.
  assign invalidate_ready_out = 1'b1;
  assign fill_ready_out       = ~invalidate_valid_in;
  assign access_ready_out     = ~invalidate_valid_in & ~fill_valid_in;

  assign inv_fire    = invalidate_valid_in;
  assign fill_fire   = fill_valid_in & ~invalidate_valid_in;
  assign access_fire = access_valid_in & ~invalidate_valid_in & ~fill_valid_in;

  assign event_way = inv_fire  ? invalidate_way_in :
                     fill_fire ? fill_way_in       : access_way_in;

  // Decode the winning event's way into a one-hot hit vector and fetch that
  // way's state. An index beyond NUM_WAY matches nothing, which is what makes
  // out-of-range requests harmless further down.
  always_comb begin
    event_hit   = '0;
    event_valid = 1'b0;
    event_age   = '0;
    for (int i = 0; i < NUM_WAY; i++) begin
      if (event_way == P'(i)) begin
        event_hit[i] = 1'b1;
        event_valid  = valid_q[i];
        event_age    = age_q[i];
      end
    end
  end

  // Next-state for the whole set. Three cases reshuffle the ages:
  //   invalidate of a valid way  - close the gap left above its age
  //   touch of a valid way       - ways younger than it age by one, it goes to 0
  //                                (a fill that hits a valid way is a touch)
  //   fill of an invalid way     - everybody valid ages by one, new way is 0
  // Anything else (invalid target, out-of-range index, idle) leaves state alone.
  always_comb begin
    valid_d = valid_q;
    age_d   = age_q;
    if (inv_fire) begin
      if (event_valid) begin
        for (int i = 0; i < NUM_WAY; i++) begin
          if (event_hit[i]) begin
            valid_d[i] = 1'b0;
            age_d[i]   = '0;
          end else if (valid_q[i] && (age_q[i] > event_age)) begin
            age_d[i] = sat_dec(age_q[i]);
          end
        end
      end
    end else if ((fill_fire || access_fire) && event_valid) begin
      for (int i = 0; i < NUM_WAY; i++) begin
        if (event_hit[i]) begin
          age_d[i] = '0;
        end else if (valid_q[i] && (age_q[i] < event_age)) begin
          age_d[i] = sat_inc(age_q[i]);
        end
      end
    end else if (fill_fire && (|event_hit)) begin
      for (int i = 0; i < NUM_WAY; i++) begin
        if (event_hit[i]) begin
          valid_d[i] = 1'b1;
          age_d[i]   = '0;
        end else if (valid_q[i]) begin
          age_d[i] = sat_inc(age_q[i]);
        end
      end
    end
  end

  // State registers. Reset empties the set: nothing valid, all ages zero.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      valid_q <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      age_q   <= age_d;
    end
  end

  // Lowest-index free way. Scanning downward lets the last hit, i.e. the
  // smallest index, win; with no free way the default 0 remains.
  always_comb begin
    free_way_out = '0;
    for (int i = NUM_WAY - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_way_out = P'(i);
      end
    end
  end

  assign free_valid_out  = ~(&valid_q);
  assign all_valid_out   = &valid_q;
  assign way_flatted_out = age_q;
  assign condition_out   = valid_q;

endmodule

// File: tb/tb_way_age_tracker.sv
// ---------------------------------------------------------------------------
// tb_way_age_tracker
//
// Directed steps followed by random traffic against way_age_tracker. The
// reference keeps the valid ways in an MRU-ordered list: a way's age is its
// position in that list, and invalid ways read as age 0.
// ---------------------------------------------------------------------------
module tb_way_age_tracker;

  localparam int NUM_WAY = 8;
  localparam int W       = 4;
  localparam int P       = $clog2(NUM_WAY) + 1;

  logic               clk_in;
  logic               reset_n_in;
  logic               invalidate_valid_in;
  logic [P-1:0]       invalidate_way_in;
  logic               invalidate_ready_out;
  logic               fill_valid_in;
  logic [P-1:0]       fill_way_in;
  logic               fill_ready_out;
  logic               access_valid_in;
  logic [P-1:0]       access_way_in;
  logic               access_ready_out;
  logic [W*NUM_WAY-1:0] way_flatted_out;
  logic [NUM_WAY-1:0] condition_out;
  logic               free_valid_out;
  logic [P-1:0]       free_way_out;
  logic               all_valid_out;

  int total = 0;
  int bad   = 0;

  // MRU-first list of valid ways.
  int mru[$];

  way_age_tracker #(
    .NUM_WAY(NUM_WAY),
    .SINGLE_WAY_WIDTH_IN_BITS(W),
    .WAY_PTR_WIDTH_IN_BITS(P)
  ) dut (
    .clk_in(clk_in),
    .reset_n_in(reset_n_in),
    .invalidate_valid_in(invalidate_valid_in),
    .invalidate_way_in(invalidate_way_in),
    .invalidate_ready_out(invalidate_ready_out),
    .fill_valid_in(fill_valid_in),
    .fill_way_in(fill_way_in),
    .fill_ready_out(fill_ready_out),
    .access_valid_in(access_valid_in),
    .access_way_in(access_way_in),
    .access_ready_out(access_ready_out),
    .way_flatted_out(way_flatted_out),
    .condition_out(condition_out),
    .free_valid_out(free_valid_out),
    .free_way_out(free_way_out),
    .all_valid_out(all_valid_out)
  );

  // 10-unit clock.
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Single comparison point: counts every check and reports any miss.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input int w);
    foreach (mru[k]) if (mru[k] == w) return k;
    return -1;
  endfunction

  // Reference update for one cycle's requests, applying only the winner.
  task automatic model_event(input bit iv, input int iw, input bit fv, input int fw,
                             input bit av, input int aw);
    int p;
    if (iv) begin
      p = pos_of(iw);
      if (p >= 0) mru.delete(p);
    end else if (fv) begin
      if (fw < NUM_WAY) begin
        p = pos_of(fw);
        if (p >= 0) mru.delete(p);
        mru.push_front(fw);
      end
    end else if (av) begin
      p = pos_of(aw);
      if (p >= 0) begin
        mru.delete(p);
        mru.push_front(aw);
      end
    end
  endtask

  // Compare all registered-state outputs against the reference list.
  task automatic check_output(input string tag);
    logic [W*NUM_WAY-1:0] exp_flat;
    logic [NUM_WAY-1:0]   exp_valid;
    logic [P-1:0]         exp_free;
    exp_flat  = '0;
    exp_valid = '0;
    foreach (mru[k]) begin
      exp_valid[mru[k]]          = 1'b1;
      exp_flat[mru[k]*W +: W]    = W'(k);
    end
    exp_free = '0;
    for (int i = NUM_WAY - 1; i >= 0; i--) if (!exp_valid[i]) exp_free = P'(i);
    check({tag, ".ages"},       64'(way_flatted_out), 64'(exp_flat));
    check({tag, ".valid"},      64'(condition_out),   64'(exp_valid));
    check({tag, ".free_valid"}, 64'(free_valid_out),  64'(mru.size() < NUM_WAY));
    check({tag, ".free_way"},   64'(free_way_out),    64'(exp_free));
    check({tag, ".all_valid"},  64'(all_valid_out),   64'(mru.size() == NUM_WAY));
  endtask

  // One clock of requests: drive, check the ready handshake, clock, update
  // the reference, then check the outputs just after the edge.
  task automatic apply_stimulus(input string tag, input bit iv, input int iw, input bit fv,
                                input int fw, input bit av, input int aw);
    invalidate_valid_in = iv;
    invalidate_way_in   = P'(iw);
    fill_valid_in       = fv;
    fill_way_in         = P'(fw);
    access_valid_in     = av;
    access_way_in       = P'(aw);
    #1;
    check({tag, ".inv_rdy"},  64'(invalidate_ready_out), 64'(1));
    check({tag, ".fill_rdy"}, 64'(fill_ready_out),       64'(!iv));
    check({tag, ".acc_rdy"},  64'(access_ready_out),     64'(!iv && !fv));
    @(posedge clk_in);
    model_event(iv, iw, fv, fw, av, aw);
    #1;
    check_output(tag);
  endtask

  task automatic idle_inputs();
    invalidate_valid_in = 1'b0;
    invalidate_way_in   = '0;
    fill_valid_in       = 1'b0;
    fill_way_in         = '0;
    access_valid_in     = 1'b0;
    access_way_in       = '0;
  endtask

  initial begin
    idle_inputs();
    reset_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_output("reset");
    reset_n_in = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 10; c++) apply_stimulus("idle", 0, 0, 0, 0, 0, 0);

    // Fill ways 0..3 back to back.
    for (int w = 0; w < 4; w++) apply_stimulus("fill4", 0, 0, 1, w, 0, 0);
    check("plan.fill4_ages",  64'(way_flatted_out), 64'h0000_0123);
    check("plan.fill4_valid", 64'(condition_out),   64'h0F);
    check("plan.fill4_free",  64'(free_way_out),    64'd4);

    apply_stimulus("acc0", 0, 0, 0, 0, 1, 0);
    check("plan.acc0_ages", 64'(way_flatted_out), 64'h0000_1230);
    apply_stimulus("inv2", 1, 2, 0, 0, 0, 0);
    check("plan.inv2_ages",  64'(way_flatted_out), 64'h0000_1020);
    check("plan.inv2_valid", 64'(condition_out),   64'h0B);
    check("plan.inv2_free",  64'(free_way_out),    64'd2);

    // All three requesters at once; the losers hold and drain in order.
    apply_stimulus("clash0", 1, 1, 1, 5, 1, 0);
    check("plan.clash_valid", 64'(condition_out), 64'h09);
    apply_stimulus("clash1", 0, 0, 1, 5, 1, 0);
    check("plan.clash_fill", 64'(condition_out), 64'h29);
    apply_stimulus("clash2", 0, 0, 0, 0, 1, 0);
    check("plan.clash_acc_ages", 64'(way_flatted_out), 64'h0010_2000);

    // Fill every way (already-valid ones act as touches).
    for (int w = 0; w < NUM_WAY; w++) apply_stimulus("fillall", 0, 0, 1, w, 0, 0);
    check("plan.all_valid",  64'(all_valid_out),  64'd1);
    check("plan.free_valid", 64'(free_valid_out), 64'd0);
    apply_stimulus("acc9",     0, 0, 0, 0, 1, 9);
    apply_stimulus("fill12",   0, 0, 1, 12, 0, 0);
    apply_stimulus("inv3",     1, 3, 0, 0, 0, 0);
    apply_stimulus("acc_inv3", 0, 0, 0, 0, 1, 3);
    apply_stimulus("inv3_again", 1, 3, 0, 0, 0, 0);
    apply_stimulus("inv_oob",  1, 15, 0, 0, 0, 0);

    // Asynchronous reset between edges with four ways valid.
    for (int w = 0; w < NUM_WAY; w++) apply_stimulus("drain", 1, w, 0, 0, 0, 0);
    for (int w = 0; w < 4; w++) apply_stimulus("refill4", 0, 0, 1, w + 2, 0, 0);
    #2;
    reset_n_in    = 1'b0;
    fill_valid_in = 1'b1;
    fill_way_in   = P'(6);
    #1;
    mru.delete();
    check_output("async_rst");
    @(posedge clk_in);
    #1;
    check_output("rst_hold");
    reset_n_in = 1'b1;
    idle_inputs();
    apply_stimulus("post_rst_fill", 0, 0, 1, 6, 0, 0);
    check("plan.post_rst_valid", 64'(condition_out), 64'h40);

    // Random traffic, including out-of-range way indices.
    for (int c = 0; c < 400; c++) begin
      apply_stimulus("rand",
                     ($urandom_range(0, 3) == 0), int'($urandom_range(0, 11)),
                     ($urandom_range(0, 1) == 0), int'($urandom_range(0, 11)),
                     ($urandom_range(0, 1) == 0), int'($urandom_range(0, 11)));
    end

    idle_inputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/way_age_tracker.md
# way_age_tracker

Holds the per-way recency state for one replacement set. It keeps a valid bit and an age counter for each way, and updates them on invalidate, fill and access events. Its flattened ages and valid mask drive the way-selection max-tree, which picks the valid way with the largest age as the victim. It also reports the lowest-index free way so the fill path can allocate without running a victim search.

## Interface
- NUM_WAY, 8, number of ways; 1..16.
- SINGLE_WAY_WIDTH_IN_BITS, 4, age counter width; must satisfy 2^width >= NUM_WAY.
- WAY_PTR_WIDTH_IN_BITS, $clog2(NUM_WAY)+1, width of way indices.
- clk_in  input  1  clock; all state updates on the rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- invalidate_valid_in  input  1  invalidate request.
- invalidate_way_in  input  WAY_PTR_WIDTH_IN_BITS  way to invalidate.
- invalidate_ready_out  output  1  tied to 1.
- fill_valid_in  input  1  fill request.
- fill_way_in  input  WAY_PTR_WIDTH_IN_BITS  way being filled.
- fill_ready_out  output  1  equals ~invalidate_valid_in.
- access_valid_in  input  1  hit/touch request.
- access_way_in  input  WAY_PTR_WIDTH_IN_BITS  way being touched.
- access_ready_out  output  1  equals ~invalidate_valid_in & ~fill_valid_in.
- way_flatted_out  output  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY  registered ages; way i occupies bits [i*W +: W].
- condition_out  output  NUM_WAY  registered valid mask.
- free_valid_out  output  1  at least one way is invalid.
- free_way_out  output  WAY_PTR_WIDTH_IN_BITS  lowest-index invalid way; 0 when none.
- all_valid_out  output  1  every way is valid.

## Operation
- State: valid[i] and age[i] for each way. Reset clears every age to 0 and every valid bit to 0.
- Output values after reset:
  - way_flatted_out = 0, condition_out = 0.
  - free_valid_out = 1, free_way_out = 0, all_valid_out = 0.
- Handshake: an event is accepted when valid & ready. At most one event is applied per cycle, with priority invalidate > fill > access. A non-accepted requester holds its request; dropping it is legal.
- Invariant: the ages of valid ways are distinct and are exactly 0..(count_valid-1). age 0 = MRU; the largest age = LRU victim.
- Invalidate of way w:
  - If valid: clear valid[w] and age[w]; every valid way with age > age[w] decrements by 1.
  - If already invalid: no effect.
- Fill of way w:
  - If invalid: set valid[w], age[w]=0; every other valid way increments by 1.
  - If already valid: treated exactly as an access to w.
- Access of way w:
  - If valid: every valid way with age < age[w] increments by 1; age[w]=0.
  - If invalid: no effect.
- Any index >= NUM_WAY is accepted with no effect.
- Increments saturate at 2^W-1 and decrements floor at 0. Neither is reachable while the invariant holds; both are defensive.
- free_way_out, free_valid_out and all_valid_out are combinational from registered state only, with no input-to-output path.
- The ready outputs are the only combinational input-to-output paths.

## Timing
- All state changes take effect at the edge that accepts the event. Outputs reflect the change in the following cycle (1-cycle latency).
- Back-to-back events are supported at one per cycle with no bubbles.
- Simultaneous invalidate, fill and access: only invalidate is applied; fill_ready_out and access_ready_out are 0 in that cycle.
- Asserting reset_n_in low mid-operation clears state immediately, regardless of clock. Requests presented during reset are discarded. The first accepted event is at the first rising edge after deassertion.

## Test plan
- Reset then idle: NUM_WAY=8, W=4 -> all outputs at reset values; free_way_out=0 for 10 cycles.
- Fill ways 0,1,2,3 in consecutive cycles -> ages {0:3,1:2,2:1,3:0}, condition_out=8'h0F, free_way_out=4 one cycle after the last fill.
- Continuing from the previous state, access way 0 -> ages {0:0,1:3,2:2,3:1}. Then invalidate way 2 -> valid 8'h0B, ages {0:0,1:2,2:0,3:1}, free_way_out=2.
- Invalidate, fill and access all asserted in the same cycle:
  - Stimulus: invalidate way 1, fill way 5, access way 0.
  - Required: only the invalidate is applied; fill_ready_out=0 and access_ready_out=0 that cycle.
  - Held requests: fill is applied next cycle, then access the cycle after.
- Fill all 8 ways -> all_valid_out=1, free_valid_out=0, ages a permutation of 0..7. Access of way 9 or of an invalid way -> state unchanged.
- Reset asserted between edges while 4 ways are valid -> outputs go to reset values before the next edge. A fill presented in the first cycle after deassertion is applied normally.
